key_sweep_ctrl: RTL and testbench

KEY_SWEEP_CTRL -- requirements
Module: key_sweep_ctrl

---
 rtl/key_sweep_if.sv | 27 ++
 rtl/key_sweep_ctrl.sv | 106 ++++++++++
 tb/tb_key_sweep_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_sweep_if.sv
// Handshake/bus bundle between a key-sweep controller and its compare harness.
// master: harness side (drives start/abort/eq_in); slave: controller side.
interface key_sweep_if #(
    parameter int KEY_W = 5,
    parameter int IN_W  = 5,
    parameter int OUT_W = 2
);
    logic             start;
    logic             abort;
    logic [OUT_W-1:0] eq_in;
    logic [KEY_W-1:0] key_out;
    logic [IN_W-1:0]  pat_out;
    logic             busy;
    logic             done;
    logic             found;
    logic [KEY_W-1:0] key_found;

    modport master (
        output start, abort, eq_in,
        input  key_out, pat_out, busy, done, found, key_found
    );

    modport slave (
        input  start, abort, eq_in,
        output key_out, pat_out, busy, done, found, key_found
    );
endinterface

// File: rtl/key_sweep_ctrl.sv
// Brute-force key sweep: applies every pattern for each key until a key makes
// all outputs match. Ports: C clock, R async active-low reset, bus (slave).
module key_sweep_ctrl #(
    parameter int KEY_W = 5,
    parameter int IN_W  = 5,
    parameter int OUT_W = 2
) (
    input  logic       C,
    input  logic       R,
    key_sweep_if.slave bus
);
    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_e;

    localparam logic [KEY_W-1:0] KEY_MAX = '1;
    localparam logic [IN_W-1:0]  PAT_MAX = '1;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [IN_W-1:0]  pat_q, pat_d;
    logic             found_q, found_d;
    logic [KEY_W-1:0] kf_q, kf_d;
    logic             all_eq;

    assign all_eq = &bus.eq_in;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
            key_q   <= '0;
            pat_q   <= '0;
            found_q <= 1'b0;
            kf_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            pat_q   <= pat_d;
            found_q <= found_d;
            kf_q    <= kf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        pat_d   = pat_q;
        found_d = found_q;
        kf_d    = kf_q;
        unique case (state_q)
            IDLE, DONE: begin
                // abort beats a coincident start
                if (bus.abort) begin
                    state_d = IDLE;
                    found_d = 1'b0;
                    kf_d    = '0;
                end else if (bus.start) begin
                    state_d = APPLY;
                    key_d   = '0;
                    pat_d   = '0;
                    found_d = 1'b0;
                    kf_d    = '0;
                end
            end
            APPLY: begin
                // one settle cycle for the combinational compare path
                if (bus.abort) begin
                    state_d = IDLE;
                    found_d = 1'b0;
                    kf_d    = '0;
                end else begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    found_d = 1'b0;
                    kf_d    = '0;
                end else if (all_eq) begin
                    if (pat_q != PAT_MAX) begin
                        pat_d   = pat_q + 1'b1;
                        state_d = APPLY;
                    end else begin
                        found_d = 1'b1;
                        kf_d    = key_q;
                        state_d = DONE;
                    end
                end else if (key_q != KEY_MAX) begin
                    key_d   = key_q + 1'b1;
                    pat_d   = '0;
                    state_d = APPLY;
                end else begin
                    // last key failed: stop without wrapping
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.key_out   = key_q;
    assign bus.pat_out   = pat_q;
    assign bus.busy      = (state_q == APPLY) || (state_q == CHECK);
    assign bus.done      = (state_q == DONE);
    assign bus.found     = found_q;
    assign bus.key_found = kf_q;
endmodule

// File: tb/tb_key_sweep_ctrl.sv
// Self-checking bench for key_sweep_ctrl: constant-eq vector table, locked
// circuit model, abort/reset/start corner cases and randomized eq tables.
module tb_key_sweep_ctrl;
    localparam int KW  = 5;
    localparam int IW  = 5;
    localparam int OW  = 2;
    localparam int NK  = 32;
    localparam int NP  = 32;
    localparam int LIM = 5000;

    typedef struct {
        logic [1:0] eq;
        int         cyc;
        bit         fnd;
        int         kf;
        int         ko;
        int         po;
    } vec_t;

    logic C = 1'b0;
    logic R = 1'b0;
    always #5 C = ~C;

    key_sweep_if #(.KEY_W(KW), .IN_W(IW), .OUT_W(OW)) bus ();

    key_sweep_ctrl #(.KEY_W(KW), .IN_W(IW), .OUT_W(OW)) dut (
        .C  (C),
        .R  (R),
        .bus(bus)
    );

    // eq_in for every (key, pattern) point of the compare harness
    logic [1:0] tab [NK][NP];
    always_comb bus.eq_in = tab[bus.key_out][bus.pat_out];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic fill_const(logic [1:0] v);
        for (int k = 0; k < NK; k++)
            for (int p = 0; p < NP; p++)
                tab[k][p] = v;
    endtask

    // SARLock-style point function: wrong key k corrupts output 0 at p==k
    function automatic logic [1:0] orig_f(int p);
        logic [4:0] q;
        q = p[4:0];
        return {^q, q[1] & q[3]};
    endfunction

    task automatic fill_locked(int ck);
        logic [1:0] lo;
        for (int k = 0; k < NK; k++)
            for (int p = 0; p < NP; p++) begin
                lo = orig_f(p) ^ {1'b0, (p == k) && (k != ck)};
                tab[k][p] = ~(lo ^ orig_f(p));
            end
    endtask

    // pass_pct: chance that a key matches on every pattern
    task automatic fill_random(int pass_pct);
        int f;
        for (int k = 0; k < NK; k++) begin
            if ($urandom_range(99) < pass_pct) begin
                for (int p = 0; p < NP; p++) tab[k][p] = 2'b11;
            end else begin
                f = ($urandom_range(3) == 0) ? $urandom_range(31) : $urandom_range(4);
                for (int p = 0; p < NP; p++) begin
                    if (p < f) tab[k][p] = 2'b11;
                    else if (p == f) tab[k][p] = 2'($urandom_range(2));
                    else tab[k][p] = 2'($urandom_range(3));
                end
            end
        end
    endtask

    // Reference: walk keys in order; each applied pattern costs 2 cycles,
    // a key stops at its first mismatching pattern.
    task automatic model(output int cyc, output bit fnd, output int kf,
                         output int ko, output int po);
        int fp;
        cyc = 0; fnd = 0; kf = 0; ko = 0; po = 0;
        for (int k = 0; k < NK; k++) begin
            fp = -1;
            for (int p = 0; p < NP && fp < 0; p++) begin
                cyc += 2;
                if (tab[k][p] != 2'b11) fp = p;
            end
            if (fp < 0) begin
                fnd = 1; kf = k; ko = k; po = NP - 1;
                return;
            end
            if (k == NK - 1) begin
                ko = k; po = fp;
                return;
            end
        end
    endtask

    task automatic run_sweep(output int cyc);
        bus.start = 1'b1;
        @(negedge C);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < LIM) begin
            cyc++;
            @(negedge C);
        end
        chk("sweep_timeout", 32'(cyc >= LIM), 0);
    endtask

    task automatic chk_end(string nm, int cyc, int ecyc, bit fnd, int kf,
                           int ko, int po);
        chk({nm, "_cycles"}, cyc, ecyc);
        chk({nm, "_done"}, bus.done, 1);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_found"}, bus.found, fnd);
        chk({nm, "_key_found"}, bus.key_found, kf);
        chk({nm, "_key_out"}, bus.key_out, ko);
        chk({nm, "_pat_out"}, bus.pat_out, po);
    endtask

    task automatic chk_zero(string nm);
        chk({nm, "_key_out"}, bus.key_out, 0);
        chk({nm, "_pat_out"}, bus.pat_out, 0);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_found"}, bus.found, 0);
        chk({nm, "_key_found"}, bus.key_found, 0);
    endtask

    vec_t vecs [4];

    initial begin
        int cyc, ecyc, kf, ko, po;
        bit fnd;

        vecs[0] = '{2'b11, 64, 1, 0, 0, 31};
        vecs[1] = '{2'b00, 64, 0, 0, 31, 0};
        vecs[2] = '{2'b01, 64, 0, 0, 31, 0};
        vecs[3] = '{2'b10, 64, 0, 0, 31, 0};

        bus.start = 1'b0;
        bus.abort = 1'b0;
        fill_const(2'b11);
        #1;
        chk_zero("reset");
        @(negedge C);
        R = 1'b1;
        repeat (2) @(negedge C);
        chk("idle_wait_busy", bus.busy, 0);

        for (int i = 0; i < 4; i++) begin
            fill_const(vecs[i].eq);
            run_sweep(cyc);
            chk_end($sformatf("vec%0d", i), cyc, vecs[i].cyc, vecs[i].fnd,
                    vecs[i].kf, vecs[i].ko, vecs[i].po);
        end

        // DONE holds its results, then abort returns to IDLE
        repeat (5) @(negedge C);
        chk("done_hold_done", bus.done, 1);
        chk("done_hold_key", bus.key_out, 31);
        bus.abort = 1'b1;
        @(negedge C);
        bus.abort = 1'b0;
        chk("done_abort_done", bus.done, 0);
        chk("done_abort_busy", bus.busy, 0);

        // locked circuit with correct key 5'b01010
        fill_locked(10);
        model(ecyc, fnd, kf, ko, po);
        run_sweep(cyc);
        chk_end("locked", cyc, ecyc, 1, 10, 10, 31);
        chk("locked_model_found", fnd, 1);

        // start while busy is ignored
        fill_const(2'b11);
        bus.start = 1'b1;
        @(negedge C);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < LIM) begin
            cyc++;
            bus.start = (cyc == 20 || cyc == 21);
            @(negedge C);
        end
        bus.start = 1'b0;
        chk("busy_start_timeout", 32'(cyc >= LIM), 0);
        chk_end("busy_start", cyc, 64, 1, 0, 0, 31);

        // abort on the 10th busy cycle (CHECK of key 4)
        fill_const(2'b00);
        bus.start = 1'b1;
        @(negedge C);
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge C);
            cyc++;
        end
        chk("abort_pre_busy", bus.busy, 1);
        bus.abort = 1'b1;
        @(negedge C);
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_found", bus.found, 0);
        chk("abort_key_hold", bus.key_out, 4);
        bus.start = 1'b1;
        @(negedge C);
        bus.start = 1'b0;
        chk("restart_busy", bus.busy, 1);
        chk("restart_key", bus.key_out, 0);
        chk("restart_pat", bus.pat_out, 0);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < LIM) begin
            cyc++;
            @(negedge C);
        end
        chk("restart_finish_timeout", 32'(cyc >= LIM), 0);

        // asynchronous reset between edges mid-sweep
        fill_const(2'b11);
        bus.start = 1'b1;
        @(negedge C);
        bus.start = 1'b0;
        repeat (7) @(negedge C);
        #2;
        R = 1'b0;
        #1;
        chk_zero("async_rst");
        @(negedge C);
        R = 1'b1;
        repeat (3) @(negedge C);
        chk_zero("post_rst_idle");
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge C);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_busy", bus.busy, 0);
        chk("start_abort_done", bus.done, 0);
        repeat (2) @(negedge C);
        chk("start_abort_stay", bus.busy, 0);

        // randomized eq tables against the reference model
        for (int t = 0; t < 8; t++) begin
            fill_random(t == 0 ? 0 : 20);
            model(ecyc, fnd, kf, ko, po);
            run_sweep(cyc);
            chk_end($sformatf("rand%0d", t), cyc, ecyc, fnd, kf, ko, po);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
